// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed asynchronous serial transmitter.
// Pops one word from a first-word-fall-through FIFO, then sends a start bit,
// DATA_W data bits LSB first, an optional parity bit and one or two stop bits.
// The line, busy and done outputs are all registered or decoded from state.
// Frame settings are latched at the pop, so the caller may change them freely
// while a frame is on the wire.
module uart_tx #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DIV_W-1:0]  i_baud_div,
    input  logic              i_parity_en,
    input  logic              i_parity_odd,
    input  logic              i_two_stop,
    input  logic [DATA_W-1:0] i_fifo_data,
    input  logic              i_fifo_valid,
    output logic              o_fifo_rd_req,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Control state (asynchronously reset).
    state_t            state_q,    state_d;
    logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q,       tx_d;
    logic              done_q,     done_d;

    // Per-frame payload and settings captured at the pop (no reset needed:
    // they are only read after a pop has loaded them).
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic [DIV_W-1:0]  div_q,      div_d;
    logic              parity_q,   parity_d;
    logic              par_en_q,   par_en_d;
    logic              two_stop_q, two_stop_d;

    logic              pop;
    logic              bit_end;

    // A pop is only allowed in IDLE, never in the done cycle, never in reset.
    assign pop     = (state_q == S_IDLE) & i_en & i_fifo_valid & ~done_q & ~i_rst;
    assign bit_end = (baud_cnt_q == '0);

    assign o_fifo_rd_req = pop;
    assign o_tx          = tx_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;

    // Next-state, bit timing and registered line value.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        shift_d    = shift_q;
        div_d      = div_q;
        parity_d   = parity_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    baud_cnt_d = i_baud_div;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    shift_d    = i_fifo_data;
                    div_d      = i_baud_div;
                    parity_d   = (^i_fifo_data) ^ i_parity_odd;
                    par_en_d   = i_parity_en;
                    two_stop_d = i_two_stop;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d    = S_DATA;
                    baud_cnt_d = div_q;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = div_q;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_W'(1);
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    baud_cnt_d = div_q;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_W'(1);
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                        baud_cnt_d = div_q;
                    end else begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        stop_cnt_d = 1'b0;
                        bit_cnt_d  = '0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - DIV_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Control registers: reset drops any frame in flight and idles the line high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // Payload and frame settings, loaded at the pop and shifted per data bit.
    always_ff @(posedge i_clk) begin
        shift_q    <= shift_d;
        div_q      <= div_d;
        parity_q   <= parity_d;
        par_en_q   <= par_en_d;
        two_stop_q <= two_stop_d;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed bench for uart_tx with a behavioural
// frame model (bit list expanded by the bit period) and a queue-based FIFO.
module tb_uart_tx;

    localparam int DATA_W  = 8;
    localparam int DIV_W   = 16;
    localparam int CAP_MAX = 256;

    logic              clk;
    logic              rst;
    logic              en;
    logic [DIV_W-1:0]  baud_div;
    logic              parity_en;
    logic              parity_odd;
    logic              two_stop;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_valid;
    logic              rd_req;
    logic              tx;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q_data[$];

    // Captured frame waveform, index 0 = first clock after the pop.
    logic w_tx   [CAP_MAX];
    logic w_busy [CAP_MAX];
    logic w_done [CAP_MAX];
    logic w_pop  [CAP_MAX];
    int         cap_len;
    int         cap_wait;
    bit         cap_got;
    logic [7:0] cap_data;
    int         cap_div;
    bit         cap_pe, cap_po, cap_ts;

    uart_tx #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_baud_div   (baud_div),
        .i_parity_en  (parity_en),
        .i_parity_odd (parity_odd),
        .i_two_stop   (two_stop),
        .i_fifo_data  (fifo_data),
        .i_fifo_valid (fifo_valid),
        .o_fifo_rd_req(rd_req),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int model_len(int div, bit pe, bit ts);
        return (1 + DATA_W + (pe ? 1 : 0) + (ts ? 2 : 1)) * (div + 1);
    endfunction

    function automatic logic model_tx(logic [7:0] d, int div, bit pe, bit po, int idx);
        int b;
        b = idx / (div + 1);
        if (b == 0) return 1'b0;
        if (b <= DATA_W) return d[b-1];
        if (pe && b == DATA_W + 1) return (^d) ^ po;
        return 1'b1;
    endfunction

    // First clock of the captured frame that deviates from the model, or -1.
    function automatic int frame_first_bad();
        for (int i = 0; i < cap_len; i++) begin
            if (w_tx[i] !== model_tx(cap_data, cap_div, cap_pe, cap_po, i) ||
                w_busy[i] !== 1'b1 || w_done[i] !== 1'b0 || w_pop[i] !== 1'b0)
                return i;
        end
        return -1;
    endfunction

    // ---------------- FIFO model ----------------
    task automatic fifo_sync();
        fifo_valid = (q_data.size() != 0);
        fifo_data  = fifo_valid ? q_data[0] : 8'h00;
    endtask

    task automatic q_push(input logic [7:0] v);
        q_data.push_back(v);
        fifo_sync();
    endtask

    task automatic q_pop();
        if (q_data.size() != 0) void'(q_data.pop_front());
        fifo_sync();
    endtask

    // Wait for a pop, latch the settings seen at the pop, then record the
    // frame plus its done cycle. At index mid_at the inputs are disturbed.
    task automatic capture_frame(input int max_wait, input int mid_at, input bit mid_en,
                                 input int mid_div, input bit mid_scr);
        cap_got  = 1'b0;
        cap_wait = 0;
        cap_len  = 0;
        for (int w = 0; w < max_wait; w++) begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                cap_got = 1'b1;
                break;
            end
            cap_wait++;
        end
        if (!cap_got) return;
        cap_data = fifo_data;
        cap_div  = int'(baud_div);
        cap_pe   = parity_en;
        cap_po   = parity_odd;
        cap_ts   = two_stop;
        @(posedge clk);
        #1;
        q_pop();
        cap_len = model_len(cap_div, cap_pe, cap_ts);
        for (int i = 0; i <= cap_len && i < CAP_MAX; i++) begin
            @(negedge clk);
            w_tx[i]   = tx;
            w_busy[i] = busy;
            w_done[i] = done;
            w_pop[i]  = rd_req;
            if (i == mid_at) begin
                en       = mid_en;
                baud_div = DIV_W'(mid_div);
                if (mid_scr) begin
                    parity_en  = 1'($urandom_range(0, 1));
                    parity_odd = 1'($urandom_range(0, 1));
                    two_stop   = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] w1;
        int bad;
        rst = 1'b1; en = 1'b1; baud_div = 16'd3;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        w1 = 8'($urandom);
        q_data.delete();
        q_push(w1);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx, busy, done, rd_req} !== 4'b1000)
            $display("FAIL reset_outputs: got tx/busy/done/rd=%b required 1000", {tx, busy, done, rd_req});
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        capture_frame(1, -1, 1'b1, 0, 1'b0);
        n_checks++;
        if (cap_got !== 1'b1) $display("FAIL reset_first_edge_pop: got %0d required 1", cap_got);
        else n_pass++;
        if (cap_got) begin
            bad = frame_first_bad();
            n_checks++;
            if (bad != -1) $display("FAIL reset_frame: first bad clock %0d required -1", bad);
            else n_pass++;
        end
    endtask

    task automatic test_basic_a5();
        logic [9:0] obs;
        int bad;
        int pops;
        en = 1'b1; baud_div = 16'd3;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        @(posedge clk);
        #1 q_push(8'hA5);
        capture_frame(10, -1, 1'b1, 0, 1'b0);
        n_checks++;
        if (cap_got !== 1'b1 || cap_data !== 8'hA5)
            $display("FAIL a5_pop: got pop=%0d data=%h required 1/a5", cap_got, cap_data);
        else n_pass++;
        for (int i = 0; i < 10; i++) obs[i] = w_tx[4*i + 1];
        n_checks++;
        if (obs !== 10'b1101001010) $display("FAIL a5_bits: got %b required 1101001010", obs);
        else n_pass++;
        bad = frame_first_bad();
        n_checks++;
        if (bad != -1) $display("FAIL a5_timing: first bad clock %0d required -1", bad);
        else n_pass++;
        n_checks++;
        if ({w_done[40], w_tx[40], w_busy[40], w_pop[40]} !== 4'b1100)
            $display("FAIL a5_done_clk41: got done/tx/busy/pop=%b required 1100",
                     {w_done[40], w_tx[40], w_busy[40], w_pop[40]});
        else n_pass++;
        pops = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_req === 1'b1) pops++;
        end
        n_checks++;
        if (pops != 0) $display("FAIL a5_single_pop: got %0d extra pops required 0", pops);
        else n_pass++;
    endtask

    task automatic test_parity();
        logic [1:0] pbit;
        int bad;
        en = 1'b1; baud_div = 16'd0; parity_en = 1'b1; two_stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            parity_odd = 1'(k);
            @(posedge clk);
            #1 q_push(8'h07);
            capture_frame(10, -1, 1'b1, 0, 1'b0);
            pbit[k] = w_tx[9];
            bad = frame_first_bad();
            n_checks++;
            if (cap_got !== 1'b1 || bad != -1)
                $display("FAIL parity_frame%0d: got pop=%0d bad=%0d required 1/-1", k, cap_got, bad);
            else n_pass++;
            n_checks++;
            if ({w_done[11], w_tx[11], w_busy[11]} !== 3'b110)
                $display("FAIL parity_len%0d: got done/tx/busy=%b at clock 12 required 110",
                         k, {w_done[11], w_tx[11], w_busy[11]});
            else n_pass++;
        end
        n_checks++;
        if (pbit !== 2'b01) $display("FAIL parity_bits: got odd/even=%b required 01", pbit);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data[2];
        int bad;
        int n_done;
        exp_data[0] = 8'h55;
        exp_data[1] = 8'hAA;
        n_done = 0;
        en = 1'b1; baud_div = 16'd1; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
        @(posedge clk);
        #1;
        q_push(8'h55);
        q_push(8'hAA);
        for (int k = 0; k < 2; k++) begin
            capture_frame(k == 0 ? 10 : 1, -1, 1'b1, 0, 1'b0);
            bad = frame_first_bad();
            n_checks++;
            if (cap_got !== 1'b1 || cap_data !== exp_data[k] || bad != -1)
                $display("FAIL b2b_frame%0d: got pop=%0d data=%h bad=%0d required 1/%h/-1",
                         k, cap_got, cap_data, bad, exp_data[k]);
            else n_pass++;
            n_checks++;
            if ({w_done[22], w_tx[22], w_busy[22], w_pop[22]} !== 4'b1100)
                $display("FAIL b2b_done%0d: got done/tx/busy/pop=%b required 1100",
                         k, {w_done[22], w_tx[22], w_busy[22], w_pop[22]});
            else n_pass++;
            if (w_done[22] === 1'b1) n_done++;
        end
        n_checks++;
        if (cap_wait != 0 || n_done != 2)
            $display("FAIL b2b_gap: got wait=%0d done_pulses=%0d required 0/2", cap_wait, n_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] w1, w2;
        bit got;
        int dones;
        int bad;
        en = 1'b1; baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        @(posedge clk);
        #1;
        q_push(w1);
        q_push(w2);
        got = 1'b0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) $display("FAIL rstmid_pop: got no pop required pop");
        else n_pass++;
        @(posedge clk);
        #1 if (got) q_pop();
        repeat (22) @(negedge clk);
        n_checks++;
        if (tx !== w1[4]) $display("FAIL rstmid_bit4: got %b required %b", tx, w1[4]);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx, busy, done, rd_req} !== 4'b1000)
            $display("FAIL rstmid_async: got tx/busy/done/rd=%b required 1000", {tx, busy, done, rd_req});
        else n_pass++;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1) dones++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        capture_frame(1, -1, 1'b1, 0, 1'b0);
        n_checks++;
        if (dones != 0) $display("FAIL rstmid_hold: got %0d bad cycles required 0", dones);
        else n_pass++;
        bad = frame_first_bad();
        n_checks++;
        if (cap_got !== 1'b1 || cap_data !== w2 || bad != -1)
            $display("FAIL rstmid_next: got pop=%0d data=%h bad=%0d required 1/%h/-1",
                     cap_got, cap_data, bad, w2);
        else n_pass++;
    endtask

    task automatic test_enable();
        logic [7:0] w1, w2;
        int pops, lows, bad;
        en = 1'b0; baud_div = 16'd2; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        @(posedge clk);
        #1;
        q_push(w1);
        q_push(w2);
        pops = 0; lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_req === 1'b1) pops++;
            if (tx !== 1'b1) lows++;
        end
        n_checks++;
        if (pops != 0 || lows != 0)
            $display("FAIL en_off_idle: got pops=%0d low_clocks=%0d required 0/0", pops, lows);
        else n_pass++;
        @(posedge clk);
        #1 en = 1'b1;
        capture_frame(2, 5, 1'b0, 2, 1'b0);
        bad = frame_first_bad();
        n_checks++;
        if (cap_got !== 1'b1 || cap_data !== w1 || bad != -1 || w_done[cap_len] !== 1'b1)
            $display("FAIL en_drop_frame: got pop=%0d data=%h bad=%0d required 1/%h/-1",
                     cap_got, cap_data, bad, w1);
        else n_pass++;
        pops = 0; lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd_req === 1'b1) pops++;
            if (tx !== 1'b1) lows++;
        end
        n_checks++;
        if (pops != 0 || lows != 0)
            $display("FAIL en_drop_nopop: got pops=%0d low_clocks=%0d required 0/0", pops, lows);
        else n_pass++;
        @(posedge clk);
        #1 en = 1'b1;
        capture_frame(2, -1, 1'b1, 0, 1'b0);
        n_checks++;
        if (cap_got !== 1'b1 || cap_data !== w2)
            $display("FAIL en_resume: got pop=%0d data=%h required 1/%h", cap_got, cap_data, w2);
        else n_pass++;
    endtask

    task automatic test_div_change();
        int bad;
        en = 1'b1; baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        @(posedge clk);
        #1;
        q_push(8'($urandom));
        q_push(8'($urandom));
        capture_frame(10, 10, 1'b1, 7, 1'b0);
        bad = frame_first_bad();
        n_checks++;
        if (cap_got !== 1'b1 || cap_div != 3 || bad != -1 || w_done[40] !== 1'b1)
            $display("FAIL div_keep: got pop=%0d div=%0d bad=%0d required 1/3/-1", cap_got, cap_div, bad);
        else n_pass++;
        capture_frame(1, -1, 1'b1, 7, 1'b0);
        bad = frame_first_bad();
        n_checks++;
        if (cap_got !== 1'b1 || cap_div != 7 || bad != -1 || w_done[80] !== 1'b1)
            $display("FAIL div_next: got pop=%0d div=%0d bad=%0d required 1/7/-1", cap_got, cap_div, bad);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        for (int k = 0; k < 8; k++) begin
            en         = 1'b1;
            baud_div   = DIV_W'($urandom_range(0, 4));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            two_stop   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            q_push(8'($urandom));
            q_push(8'($urandom));
            for (int f = 0; f < 2; f++) begin
                capture_frame(f == 0 ? 10 : 1, int'($urandom_range(0, 10)), 1'b1,
                              int'($urandom_range(0, 4)), 1'b1);
                bad = frame_first_bad();
                n_checks++;
                if (cap_got !== 1'b1 || cap_wait != 0 || bad != -1 ||
                    {w_done[cap_len], w_tx[cap_len], w_busy[cap_len], w_pop[cap_len]} !== 4'b1100)
                    $display("FAIL rand%0d_%0d: got pop=%0d wait=%0d bad=%0d data=%h div=%0d pe=%0d po=%0d ts=%0d required 1/0/-1",
                             k, f, cap_got, cap_wait, bad, cap_data, cap_div, cap_pe, cap_po, cap_ts);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; baud_div = '0;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        fifo_data = '0; fifo_valid = 1'b0;
        test_reset();
        test_basic_a5();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_div_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame.
REQ-002 SHALL have parameter DIV_W, default 16, baud divider width.
REQ-003 SHALL have port i_clk  input  1  single clock for all logic.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_en  input  1  transmitter enable; gates new frame starts only.
REQ-006 SHALL have port i_baud_div  input  DIV_W  clocks per bit minus 1.
REQ-007 SHALL have port i_parity_en  input  1  append parity bit.
REQ-008 SHALL have port i_parity_odd  input  1  1 selects odd parity, 0 selects even parity.
REQ-009 SHALL have port i_two_stop  input  1  1 selects two stop bits, 0 selects one.
REQ-010 SHALL have port i_fifo_data  input  DATA_W  first-word-fall-through FIFO head word.
REQ-011 SHALL have port i_fifo_valid  input  1  FIFO head word valid.
REQ-012 SHALL have port o_fifo_rd_req  output  1  FIFO pop, one cycle per word.
REQ-013 SHALL have port o_tx  output  1  serial line, registered, idle high.
REQ-014 SHALL have port o_busy  output  1  frame in progress.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-017 SHALL drive o_fifo_rd_req combinationally as (state==IDLE) & i_en & i_fifo_valid, for at most one cycle per frame.
REQ-018 SHALL, on a pop edge, capture i_fifo_data, i_baud_div, i_parity_en, i_parity_odd and i_two_stop, and enter START; later input changes SHALL NOT affect the current frame.
REQ-019 SHALL drive o_tx low from the cycle after the pop; each bit SHALL last exactly div+1 clocks, where div is the captured i_baud_div (div=0 gives 1 clock per bit).
REQ-020 SHALL transmit the data bits LSB first in the DATA state, using a bit counter from 0 to DATA_W-1.
REQ-021 SHALL, when parity is enabled, send PARITY = (XOR of the data bits) XOR parity_odd.
REQ-022 SHALL hold o_tx high in STOP for 1 bit period, or 2 when two-stop is set.
REQ-023 SHALL make a frame last (1+DATA_W+P+S)*(div+1) clocks, where P is 0 or 1 and S is 1 or 2.
REQ-024 SHALL pulse o_done for one cycle in the first IDLE cycle after STOP.
REQ-025 SHALL NOT pop in that done cycle, so there is a minimum of 1 idle clock (o_tx=1) between back-to-back frames.
REQ-026 SHALL assert o_busy in every state except IDLE.
REQ-027 SHALL let a frame in progress complete normally when i_en deasserts mid-frame; no further pop SHALL occur while i_en=0.
REQ-028 SHALL hold o_tx=1 and issue no pop in IDLE while i_fifo_valid=0.
REQ-029 SHALL implement the baud counter as a DIV_W-bit down-counter reloaded with div at each bit boundary, with no wrap beyond div.

Reset
REQ-030 SHALL, while i_rst=1 (asynchronously, including mid-frame), force state IDLE, o_tx=1, o_busy=0, o_done=0, o_fifo_rd_req=0, and clear all counters; a partially sent byte SHALL be discarded with no o_done.
REQ-031 SHALL, after release of i_rst, allow a pop on the first clock edge.

Verification
REQ-032 SHALL cover: div=3, no parity, 1 stop, push 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks (40 total); o_done pulses at clock 41; exactly one pop.
REQ-033 SHALL cover: div=0, parity enabled, push 0x07 with parity_odd=0 -> parity bit 1; repeat with parity_odd=1 -> parity bit 0; frame 11 clocks.
REQ-034 SHALL cover: div=1, two stop bits, FIFO holds 0x55 then 0xAA -> two pops, each frame 22 clocks, 1 idle-high clock between frames, two o_done pulses.
REQ-035 SHALL cover: i_rst asserted during data bit 4 -> o_tx=1 and o_busy=0 immediately, no o_done; after release, the next FIFO word is sent as a full frame.
REQ-036 SHALL cover: i_en=0 with i_fifo_valid=1 -> no pop and o_tx stays 1; i_en dropped mid-frame -> frame completes, then no further pop.
REQ-037 SHALL cover: i_baud_div changed from 3 to 7 mid-frame -> current frame keeps 4 clocks per bit; the next frame uses 8.
